// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU: default width and operation codes.
// op[2] inverts B and forces carry-in; op[1:0] selects the function.
package alu_pkg;
  localparam int WIDTH = 16;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_RSVD  = 3'b011;
  localparam logic [2:0] OP_AND_N = 3'b100;
  localparam logic [2:0] OP_OR_N  = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: next result, zero, carry and signed overflow.
// A single adder serves ADD, SUB and SLT through the B-invert / carry-in path.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result_nxt,
  output logic             zero_nxt,
  output logic             carry_nxt,
  output logic             overflow_nxt
);
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] bb_s;
  logic        [WIDTH:0]   sum_ext;
  logic signed [WIDTH-1:0] sum_s;
  logic                    add_ovf;

  assign a_s     = a;
  assign bb_s    = op[2] ? ~b : b;
  assign sum_ext = {1'b0, a_s} + {1'b0, bb_s} + {{WIDTH{1'b0}}, op[2]};
  assign sum_s   = sum_ext[WIDTH-1:0];

  // Overflow: both adder inputs share a sign that the sum does not.
  assign add_ovf = (a_s[WIDTH-1] == bb_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);

  always_comb begin
    result_nxt   = '0;
    carry_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    case (op)
      OP_AND, OP_AND_N: result_nxt = a_s & bb_s;
      OP_OR,  OP_OR_N:  result_nxt = a_s | bb_s;
      OP_ADD, OP_SUB: begin
        result_nxt   = sum_s;
        carry_nxt    = sum_ext[WIDTH];
        overflow_nxt = add_ovf;
      end
      OP_SLT:  result_nxt = {{(WIDTH-1){1'b0}}, sum_s[WIDTH-1] ^ add_ovf};
      OP_RSVD: result_nxt = '0;
      default: result_nxt = '0;
    endcase
  end

  assign zero_nxt = (result_nxt == '0);
endmodule

// File: rtl/alu_16.sv
// 16-bit MIPS-style ALU: combinational core followed by one output register stage.
// Outputs hold while in_valid is low; out_valid marks a fresh result.
module alu_16
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             out_valid,
  output logic             carry_out,
  output logic             overflow
);
  logic [WIDTH-1:0] result_p0;
  logic             zero_p0;
  logic             carry_p0;
  logic             overflow_p0;

  logic signed [WIDTH-1:0] result_p1;
  logic                    zero_p1;
  logic                    carry_p1;
  logic                    overflow_p1;
  logic                    vld_p1;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op           (op),
    .a            (a),
    .b            (b),
    .result_nxt   (result_p0),
    .zero_nxt     (zero_p0),
    .carry_nxt    (carry_p0),
    .overflow_nxt (overflow_p0)
  );

  // Stage p0 -> p1: capture on valid, otherwise hold; reset clears an in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1   <= '0;
      zero_p1     <= 1'b1;
      carry_p1    <= 1'b0;
      overflow_p1 <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1   <= result_p0;
        zero_p1     <= zero_p0;
        carry_p1    <= carry_p0;
        overflow_p1 <= overflow_p0;
      end
    end
  end

  assign result    = result_p1;
  assign zero      = zero_p1;
  assign carry_out = carry_p1;
  assign overflow  = overflow_p1;
  assign out_valid = vld_p1;
endmodule

// File: tb/tb_alu_16.sv
// Self-checking bench for alu_16: directed vector table, handshake/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_alu_16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        in_valid;
  logic [15:0] result;
  logic        zero, out_valid, carry_out, overflow;

  int tests = 0;
  int fails = 0;

  alu_16 dut (
    .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b), .in_valid(in_valid),
    .result(result), .zero(zero), .out_valid(out_valid),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] r, input logic z,
                           input logic c, input logic v, input logic ov);
    check({name, ".result"}, {16'h0, result}, {16'h0, r});
    check({name, ".zero"}, {31'h0, zero}, {31'h0, z});
    check({name, ".carry"}, {31'h0, carry_out}, {31'h0, c});
    check({name, ".ovf"}, {31'h0, overflow}, {31'h0, v});
    check({name, ".out_valid"}, {31'h0, out_valid}, {31'h0, ov});
  endtask

  // Drive at negedge, let one rising edge occur, sample 1 time unit later.
  task automatic step(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                      input logic v);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Reference model from the arithmetic definition of each operation.
  task automatic model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] r, output logic c, output logic v);
    int sx, sy, s;
    sx = $signed(x);
    sy = $signed(y);
    r = '0; c = 1'b0; v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b100: r = x & ~y;
      3'b101: r = x | ~y;
      3'b010: begin
        r = 16'(int'(x) + int'(y));
        c = (int'(x) + int'(y)) > 65535;
        s = sx + sy;
        v = (s > 32767) || (s < -32768);
      end
      3'b110: begin
        r = 16'(int'(x) - int'(y));
        c = (x >= y);
        s = sx - sy;
        v = (s > 32767) || (s < -32768);
      end
      3'b111: r = (sx < sy) ? 16'd1 : 16'd0;
      default: r = '0;
    endcase
  endtask

  initial begin
    logic [15:0] er;
    logic        ec, ev, ez, vin;
    logic [2:0]  ro;
    logic [15:0] ra, rb;

    vecs.push_back('{3'b000, 16'h0007, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b001, 16'h0005, 16'h0002, 16'h0007, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b100, 16'h0007, 16'h0001, 16'h0006, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b101, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'b010, 16'h0005, 16'h0001, 16'h0006, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b010, 16'h0007, 16'h0001, 16'h0008, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b110, 16'h0005, 16'h0001, 16'h0004, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 16'h000F, 16'h0001, 16'h000E, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{3'b110, 16'h0003, 16'h0003, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{3'b110, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{3'b111, 16'h0005, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 16'h000E, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b111, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{3'b011, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0});

    rst_n = 1'b0; op = '0; a = '0; b = '0; in_valid = 1'b0;
    #12;
    check_out("reset", 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      check_out($sformatf("vec%0d", i), vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].v, 1'b1);
    end

    // Handshake: invalid cycles hold data with new operands presented, out_valid drops.
    step(3'b010, 16'h7FFF, 16'h0001, 1'b1);
    check_out("hs_v1", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    step(3'b001, 16'h00F0, 16'h000F, 1'b0);
    check_out("hs_i1", 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(3'b001, 16'h00F0, 16'h000F, 1'b1);
    check_out("hs_v2", 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1);
    step(3'b110, 16'h0001, 16'h0002, 1'b0);
    check_out("hs_i2", 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3'b110, 16'h0001, 16'h0002, 1'b1);
    check_out("hs_v3", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);

    // Mid-stream asynchronous reset, then first capture after release.
    step(3'b010, 16'hFFFF, 16'h0001, 1'b1);
    @(negedge clk);
    op = 3'b000; a = 16'hFFFF; b = 16'h00AA; in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_out("async_rst", 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_out("rst_hold", 16'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst", 16'h00AA, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model; expected outputs hold on invalid cycles.
    model(3'b000, 16'hFFFF, 16'h00AA, er, ec, ev);
    ez = (er == 16'h0);
    for (int i = 0; i < 300; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ra;
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 7) == 0) rb = 16'h7FFF;
      vin = ($urandom_range(0, 3) != 0);
      step(ro, ra, rb, vin);
      if (vin) begin
        model(ro, ra, rb, er, ec, ev);
        ez = (er == 16'h0);
      end
      check_out($sformatf("rnd%0d_op%0d", i, ro), er, ez, ec, ev, vin);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
